teclado_cajero: RTL and testbench
=================================

// Module: teclado_cajero
// PURPOSE
//  Upstream keypad front end for the cajero FSM. Scans a 4x4 matrix keypad,
//  debounces presses and produces the DIGITO/DIGITO_STB (PIN entry) and
//  MONTO/MONTO_STB (decimal amount entry) inputs consumed by cajero.
//  Exactly one event is produced per physical press, regardless of hold time or bounce.
// PARAMETERS
//  SCAN_CYCLES      2  cycles each column is driven before FILAS is sampled
//  DEBOUNCE_CYCLES  4  consecutive stable cycles needed to accept a press or a release
//  MAX_DIGITOS      9  max decimal digits in an amount (999999999 < 2^32)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  FILAS       in   4   keypad rows; bit r=1 means key (r, driven column) is pressed
//  COLUMNAS    out  4   one-hot column drive, active-high
//  MODO_MONTO  in   1   0 = PIN digit mode, 1 = amount accumulation mode
//  DIGITO      out  4   last accepted digit value, 0-9
//  DIGITO_STB  out  1   1-cycle pulse, DIGITO valid (PIN mode only)
//  MONTO       out  32  last entered amount, unsigned binary
//  MONTO_STB   out  1   1-cycle pulse, MONTO valid (amount mode only)
//  EXCESO      out  1   1-cycle pulse, digit rejected because MAX_DIGITOS was reached
// BEHAVIOUR
//  Reset (async): COLUMNAS=4'b0001, DIGITO=0, DIGITO_STB=0, MONTO=0, MONTO_STB=0,
//   EXCESO=0, accumulator=0, digit count=0, state=SCAN, column index=0. No strobe fires
//   on a reset edge. A key held through reset release is reported once as a new press.
//  Key map (row r, column c): r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
//  FSM:
//   SCAN: drive column idx for SCAN_CYCLES cycles, then sample FILAS on the last cycle.
//    Exactly one bit set -> latch (row, col), cnt=0, go to DEBOUNCE.
//    Zero bits or >1 bit (ghost/multi-key) -> idx=idx+1 (3 wraps to 0), stay in SCAN.
//   DEBOUNCE: hold the column. FILAS==latched one-hot row -> cnt++. Any mismatch -> SCAN,
//    same column, no event. After DEBOUNCE_CYCLES matching cycles -> EMIT.
//   EMIT: one cycle. Perform the key action, then go to RELEASE.
//   RELEASE: hold the column. FILAS==0 -> cnt++, any nonzero -> cnt=0.
//    After DEBOUNCE_CYCLES zero cycles -> SCAN with idx+1. No auto-repeat.
//  Latency: strobe is registered and appears DEBOUNCE_CYCLES+1 clocks after the
//   capturing SCAN sample edge. Every strobe lasts exactly one cycle.
//  EMIT actions, MODO_MONTO=0: digit -> DIGITO=value, DIGITO_STB=1. *, #, A-D ignored.
//   DIGITO holds its value between strobes.
//  EMIT actions, MODO_MONTO=1:
//   digit, count<MAX_DIGITOS -> acc = (acc<<3)+(acc<<1)+value (32-bit), count++.
//   digit, count==MAX_DIGITOS -> acc unchanged, EXCESO=1.
//   * -> acc=0, count=0.
//   # with count>0 -> MONTO=acc, MONTO_STB=1, acc=0, count=0.
//   # with count==0 -> ignored, no strobe. A-D ignored.
//   No DIGITO_STB is ever produced in this mode.
//  Mode change: in any cycle where MODO_MONTO differs from its registered copy,
//   acc and count are cleared and any EMIT action in that same cycle is dropped
//   (the FSM still advances to RELEASE).
//  DIGITO_STB, MONTO_STB and EXCESO are mutually exclusive.
// TESTING
//  1 MODO=0, hold key 5 (c1,r1) for 60 cycles -> one DIGITO_STB with DIGITO=5, no
//    repeat. Release, press again -> a second single strobe.
//  2 MODO=0, key 8 bouncing every 2 cycles for 12 cycles, then stable -> exactly one
//    DIGITO_STB with DIGITO=8. Bounce on release -> no extra strobe.
//  3 MODO=1, keys 1,2,5,0,# -> MONTO=1250, one MONTO_STB, zero DIGITO_STB.
//  4 MODO=1, ten presses of 9, then # -> EXCESO on the 10th press, MONTO=999999999.
//  5 MODO=1, keys 4,7,*,3,# -> MONTO=3. Then # alone -> no MONTO_STB.
//    Keys 6, toggle MODO, then # -> no strobe.
//  6 Keys 1 and 4 pressed together in column 0 -> no event. Assert rst during DEBOUNCE
//    of key 2 -> all outputs at reset values immediately, no strobe. Key still held
//    after release -> one DIGITO_STB with DIGITO=2.

Source files
------------

// File: rtl/teclado_cajero.sv
// 4x4 matrix keypad scanner with debouncing for the cajero FSM: emits PIN digits
// in digit mode and accumulates decimal amounts in amount mode.
module teclado_cajero #(
  parameter int SCAN_CYCLES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITOS     = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  FILAS,
  output logic [3:0]  COLUMNAS,
  input  logic        MODO_MONTO,
  output logic [3:0]  DIGITO,
  output logic        DIGITO_STB,
  output logic [31:0] MONTO,
  output logic        MONTO_STB,
  output logic        EXCESO
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int NW = $clog2(MAX_DIGITOS + 1);

  localparam logic [3:0] K_A    = 4'd10;
  localparam logic [3:0] K_B    = 4'd11;
  localparam logic [3:0] K_C    = 4'd12;
  localparam logic [3:0] K_D    = 4'd13;
  localparam logic [3:0] K_STAR = 4'd14;
  localparam logic [3:0] K_HASH = 4'd15;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

  // Codes 0-9 are digits; letters, * and # get the codes above.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] k;
    case ({row, col})
      4'b00_00: k = 4'd1;
      4'b00_01: k = 4'd2;
      4'b00_10: k = 4'd3;
      4'b00_11: k = K_A;
      4'b01_00: k = 4'd4;
      4'b01_01: k = 4'd5;
      4'b01_10: k = 4'd6;
      4'b01_11: k = K_B;
      4'b10_00: k = 4'd7;
      4'b10_01: k = 4'd8;
      4'b10_10: k = 4'd9;
      4'b10_11: k = K_C;
      4'b11_00: k = K_STAR;
      4'b11_01: k = 4'd0;
      4'b11_10: k = K_HASH;
      default:  k = K_D;
    endcase
    return k;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] v);
    logic [1:0] r;
    case (v)
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // acc*10 + digit using shifts; wraps at 32 bits (cannot happen below MAX_DIGITOS=9).
  function automatic logic [31:0] mul10_add(input logic [31:0] a, input logic [3:0] d);
    return (a << 3) + (a << 1) + {28'd0, d};
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [DW-1:0]   db_cnt_q, db_cnt_d;
  logic [3:0]      row_q, row_d;
  logic            modo_q;
  logic [31:0]     acc_q, acc_d;
  logic [NW-1:0]   ndig_q, ndig_d;

  logic [3:0]      digito_p1, digito_d;
  logic            dstb_p1, dstb_d;
  logic [31:0]     monto_p1, monto_d;
  logic            mstb_p1, mstb_d;
  logic            exc_p1, exc_d;

  logic            mode_chg;
  logic [3:0]      key;

  assign mode_chg = (MODO_MONTO != modo_q);
  assign key      = key_code(row_index(row_q), col_idx_q);

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    scan_cnt_d = scan_cnt_q;
    db_cnt_d   = db_cnt_q;
    row_d      = row_q;
    acc_d      = acc_q;
    ndig_d     = ndig_q;
    digito_d   = digito_p1;
    monto_d    = monto_p1;
    dstb_d     = 1'b0;
    mstb_d     = 1'b0;
    exc_d      = 1'b0;

    case (state_q)
      SCAN: begin
        if (scan_cnt_q == SW'(SCAN_CYCLES - 1)) begin
          scan_cnt_d = '0;
          if (is_onehot(FILAS)) begin
            row_d    = FILAS;
            db_cnt_d = '0;
            state_d  = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (FILAS == row_q) begin
          if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt_d = '0;
            state_d  = EMIT;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end else begin
          scan_cnt_d = '0;
          state_d    = SCAN;
        end
      end
      EMIT: begin
        state_d  = RELEASE;
        db_cnt_d = '0;
        if (!mode_chg) begin
          if (!MODO_MONTO) begin
            if (key <= 4'd9) begin
              digito_d = key;
              dstb_d   = 1'b1;
            end
          end else if (key <= 4'd9) begin
            if (ndig_q < NW'(MAX_DIGITOS)) begin
              acc_d  = mul10_add(acc_q, key);
              ndig_d = ndig_q + 1'b1;
            end else begin
              exc_d = 1'b1;
            end
          end else if (key == K_STAR) begin
            acc_d  = '0;
            ndig_d = '0;
          end else if (key == K_HASH && ndig_q != '0) begin
            monto_d = acc_q;
            mstb_d  = 1'b1;
            acc_d   = '0;
            ndig_d  = '0;
          end
        end
      end
      RELEASE: begin
        if (FILAS == 4'd0) begin
          if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt_d   = '0;
            scan_cnt_d = '0;
            col_idx_d  = col_idx_q + 2'd1;
            state_d    = SCAN;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end else begin
          db_cnt_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase

    // A mode switch abandons any partially entered amount.
    if (mode_chg) begin
      acc_d  = '0;
      ndig_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SCAN;
      col_idx_q  <= '0;
      scan_cnt_q <= '0;
      db_cnt_q   <= '0;
      row_q      <= '0;
      modo_q     <= 1'b0;
      acc_q      <= '0;
      ndig_q     <= '0;
    end else begin
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      scan_cnt_q <= scan_cnt_d;
      db_cnt_q   <= db_cnt_d;
      row_q      <= row_d;
      modo_q     <= MODO_MONTO;
      acc_q      <= acc_d;
      ndig_q     <= ndig_d;
    end
  end

  // Output stage: key actions become visible one clock after the EMIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digito_p1 <= '0;
      dstb_p1   <= 1'b0;
      monto_p1  <= '0;
      mstb_p1   <= 1'b0;
      exc_p1    <= 1'b0;
    end else begin
      digito_p1 <= digito_d;
      dstb_p1   <= dstb_d;
      monto_p1  <= monto_d;
      mstb_p1   <= mstb_d;
      exc_p1    <= exc_d;
    end
  end

  assign COLUMNAS   = 4'b0001 << col_idx_q;
  assign DIGITO     = digito_p1;
  assign DIGITO_STB = dstb_p1;
  assign MONTO      = monto_p1;
  assign MONTO_STB  = mstb_p1;
  assign EXCESO     = exc_p1;

endmodule

// File: tb/tb_teclado_cajero.sv
// Directed bench for teclado_cajero: a keypad matrix model driven from a key bitmap,
// a table of single presses with hand-computed results, and multi-cycle corner cases.
module tb_teclado_cajero;

  logic        clk = 1'b0;
  logic        rst;
  logic        MODO_MONTO;
  logic [3:0]  FILAS, COLUMNAS, DIGITO;
  logic        DIGITO_STB, MONTO_STB, EXCESO;
  logic [31:0] MONTO;
  logic [15:0] keys;  // bit r*4+c = key at row r, column c held down

  always #5 clk = ~clk;

  always_comb begin
    FILAS = 4'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (COLUMNAS[c] && keys[r*4+c]) FILAS[r] = 1'b1;
  end

  teclado_cajero dut (
    .clk(clk), .rst(rst), .FILAS(FILAS), .COLUMNAS(COLUMNAS), .MODO_MONTO(MODO_MONTO),
    .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB), .MONTO(MONTO), .MONTO_STB(MONTO_STB),
    .EXCESO(EXCESO)
  );

  int n_dstb = 0, n_mstb = 0, n_exc = 0, excl_err = 0;
  int n_pass = 0, n_checks = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (DIGITO_STB) n_dstb++;
      if (MONTO_STB)  n_mstb++;
      if (EXCESO)     n_exc++;
      if (int'(DIGITO_STB) + int'(MONTO_STB) + int'(EXCESO) > 1) excl_err++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic press_release(input int pos, input int hold, input int rel);
    keys[pos] = 1'b1;
    repeat (hold) @(negedge clk);
    keys[pos] = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  typedef struct {
    logic        modo;
    int          pos;    // r*4+c
    int          d;      // expected DIGITO_STB pulses
    logic [3:0]  dig;
    int          m;      // expected MONTO_STB pulses
    logic [31:0] monto;
    int          e;      // expected EXCESO pulses
  } vec_t;

  vec_t tbl[18];
  int d0, m0, e0;

  initial begin
    // Positions: 1=0 2=1 3=2 A=3 4=4 5=5 6=6 B=7 7=8 8=9 9=10 C=11 *=12 0=13 #=14 D=15
    tbl[0]  = '{1'b0, 5,  1, 4'd5, 0, 32'd0,    0};
    tbl[1]  = '{1'b0, 9,  1, 4'd8, 0, 32'd0,    0};
    tbl[2]  = '{1'b0, 13, 1, 4'd0, 0, 32'd0,    0};
    tbl[3]  = '{1'b0, 12, 0, 4'd0, 0, 32'd0,    0};
    tbl[4]  = '{1'b0, 3,  0, 4'd0, 0, 32'd0,    0};
    tbl[5]  = '{1'b0, 10, 1, 4'd9, 0, 32'd0,    0};
    tbl[6]  = '{1'b1, 0,  0, 4'd9, 0, 32'd0,    0};
    tbl[7]  = '{1'b1, 1,  0, 4'd9, 0, 32'd0,    0};
    tbl[8]  = '{1'b1, 5,  0, 4'd9, 0, 32'd0,    0};
    tbl[9]  = '{1'b1, 13, 0, 4'd9, 0, 32'd0,    0};
    tbl[10] = '{1'b1, 14, 0, 4'd9, 1, 32'd1250, 0};
    tbl[11] = '{1'b1, 4,  0, 4'd9, 0, 32'd1250, 0};
    tbl[12] = '{1'b1, 8,  0, 4'd9, 0, 32'd1250, 0};
    tbl[13] = '{1'b1, 12, 0, 4'd9, 0, 32'd1250, 0};
    tbl[14] = '{1'b1, 2,  0, 4'd9, 0, 32'd1250, 0};
    tbl[15] = '{1'b1, 14, 0, 4'd9, 1, 32'd3,    0};
    tbl[16] = '{1'b1, 14, 0, 4'd9, 0, 32'd3,    0};
    tbl[17] = '{1'b1, 15, 0, 4'd9, 0, 32'd3,    0};

    rst = 1'b1;
    MODO_MONTO = 1'b0;
    keys = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_columnas", {28'd0, COLUMNAS}, 32'd1);
    chk("rst_digito", {28'd0, DIGITO}, 32'd0);
    chk("rst_monto", MONTO, 32'd0);
    chk("rst_strobes", {29'd0, DIGITO_STB, MONTO_STB, EXCESO}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("scan_col1", {28'd0, COLUMNAS}, 32'd2);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      MODO_MONTO = tbl[i].modo;
      d0 = n_dstb; m0 = n_mstb; e0 = n_exc;
      press_release(tbl[i].pos, 30, 20);
      chk($sformatf("vec%0d_dstb", i), n_dstb - d0, tbl[i].d);
      chk($sformatf("vec%0d_mstb", i), n_mstb - m0, tbl[i].m);
      chk($sformatf("vec%0d_exceso", i), n_exc - e0, tbl[i].e);
      chk($sformatf("vec%0d_digito", i), {28'd0, DIGITO}, {28'd0, tbl[i].dig});
      chk($sformatf("vec%0d_monto", i), MONTO, tbl[i].monto);
    end

    // Ten nines: the tenth exceeds the digit limit.
    MODO_MONTO = 1'b1;
    d0 = n_dstb; m0 = n_mstb; e0 = n_exc;
    for (int i = 0; i < 9; i++) press_release(10, 30, 20);
    chk("nines9_exceso", n_exc - e0, 32'd0);
    press_release(10, 30, 20);
    chk("nines10_exceso", n_exc - e0, 32'd1);
    press_release(14, 30, 20);
    chk("nines_mstb", n_mstb - m0, 32'd1);
    chk("nines_monto", MONTO, 32'd999999999);
    chk("nines_no_dstb", n_dstb - d0, 32'd0);

    // Mode toggle discards the partial amount "6".
    m0 = n_mstb;
    press_release(6, 30, 20);
    MODO_MONTO = 1'b0;
    repeat (3) @(negedge clk);
    MODO_MONTO = 1'b1;
    repeat (3) @(negedge clk);
    press_release(14, 30, 20);
    chk("toggle_no_mstb", n_mstb - m0, 32'd0);
    chk("toggle_monto", MONTO, 32'd999999999);

    // Long hold of 5: one strobe, no auto-repeat; second press gives one more.
    MODO_MONTO = 1'b0;
    repeat (3) @(negedge clk);
    d0 = n_dstb;
    press_release(5, 60, 20);
    chk("hold5_dstb", n_dstb - d0, 32'd1);
    chk("hold5_digito", {28'd0, DIGITO}, 32'd5);
    press_release(5, 30, 20);
    chk("hold5_again", n_dstb - d0, 32'd2);

    // Bouncing 8 on press and on release.
    d0 = n_dstb;
    for (int i = 0; i < 3; i++) begin
      keys[9] = 1'b1; repeat (2) @(negedge clk);
      keys[9] = 1'b0; repeat (2) @(negedge clk);
    end
    keys[9] = 1'b1; repeat (30) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      keys[9] = 1'b0; repeat (2) @(negedge clk);
      keys[9] = 1'b1; repeat (2) @(negedge clk);
    end
    keys[9] = 1'b0; repeat (20) @(negedge clk);
    chk("bounce8_dstb", n_dstb - d0, 32'd1);
    chk("bounce8_digito", {28'd0, DIGITO}, 32'd8);

    // Keys 1 and 4 share column 0: ghost, no event.
    d0 = n_dstb;
    keys[0] = 1'b1; keys[4] = 1'b1;
    repeat (40) @(negedge clk);
    keys[0] = 1'b0; keys[4] = 1'b0;
    repeat (20) @(negedge clk);
    chk("ghost_no_dstb", n_dstb - d0, 32'd0);

    // Reset in the middle of debouncing key 2, then key still held after release.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    keys[1] = 1'b1;
    d0 = n_dstb;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_columnas", {28'd0, COLUMNAS}, 32'd1);
    chk("midrst_digito", {28'd0, DIGITO}, 32'd0);
    chk("midrst_monto", MONTO, 32'd0);
    chk("midrst_strobes", {29'd0, DIGITO_STB, MONTO_STB, EXCESO}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("midrst_no_dstb", n_dstb - d0, 32'd0);
    repeat (8) @(negedge clk);
    chk("latency_before", {31'd0, DIGITO_STB}, 32'd0);
    @(negedge clk);
    chk("latency_stb", {31'd0, DIGITO_STB}, 32'd1);
    chk("latency_digito", {28'd0, DIGITO}, 32'd2);
    repeat (20) @(negedge clk);
    keys[1] = 1'b0;
    repeat (20) @(negedge clk);
    chk("held2_dstb", n_dstb - d0, 32'd1);

    chk("strobe_exclusive", excl_err, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
